// File: rtl/vector_pkg.sv
// Shared types and width helpers for the vector result streaming path.
package vector_pkg;

   // Streamer control states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } stream_state_t;

   // Width of a field that must hold any count from 0 to n inclusive.
   function automatic int lw_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Width of an index that addresses n entries (at least one bit).
   function automatic int iw_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vector_snapshot_buffer.sv
// N x BITS snapshot store: captures a whole vector in one edge, read by index.
module vector_snapshot_buffer
   import vector_pkg::*;
#(
   parameter int BITS = 8,
   parameter int N    = 64,
   parameter int IW   = iw_width(N)
) (
   input  logic            clk,
   input  logic            load,
   input  logic [BITS-1:0] din [N],
   input  logic [IW-1:0]   rd_idx,
   output logic [BITS-1:0] rd_data
);

   logic [BITS-1:0] mem [N];

   // Capture every element together so later changes on din cannot leak in.
   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < N; i++) begin
            mem[i] <= din[i];
         end
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/vector_result_streamer.sv
// Captures a result vector on start and streams its first min(len, N)
// elements out one per accepted beat, then pulses done.
//
// Output handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid is a register and never waits for
// out_ready; while out_valid=1 and out_ready=0, out_data, out_index and
// out_last hold their values until the beat transfers.
module vector_result_streamer
   import vector_pkg::*;
#(
   parameter int BITS = 8,
   parameter int N    = 64,
   parameter int LW   = lw_width(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] S [N],
   input  logic            start,
   input  logic [LW-1:0]   len,
   input  logic            out_ready,
   output logic [BITS-1:0] out_data,
   output logic            out_valid,
   output logic [LW-1:0]   out_index,
   output logic            out_last,
   output logic            busy,
   output logic            done
);

   localparam int            IW    = iw_width(N);
   localparam logic [LW-1:0] N_LEN = LW'(N);

   // state is the observable FSM state for checkers and debug.
   stream_state_t   state;
   logic [LW-1:0]   idx;
   logic [LW-1:0]   eff_len;
   logic [LW-1:0]   idx_inc;
   logic [LW-1:0]   len_clamped;
   logic            load;
   logic [BITS-1:0] rd_data;

   // Oversized requests are clamped to the vector length, never rejected.
   assign len_clamped = (len > N_LEN) ? N_LEN : len;
   assign idx_inc     = idx + LW'(1);

   // Snapshot only on an accepted non-empty start.
   assign load = (state == ST_IDLE) && start && (len != '0) && !rst;

   vector_snapshot_buffer #(
      .BITS (BITS),
      .N    (N),
      .IW   (IW)
   ) u_snapshot (
      .clk     (clk),
      .load    (load),
      .din     (S),
      .rd_idx  (idx[IW-1:0]),
      .rd_data (rd_data)
   );

   // idx is held at 0 outside STREAM, so out_index is 0 there as well.
   assign out_index = idx;
   assign out_data  = out_valid ? rd_data : '0;

   // Control FSM: accepts start in IDLE, walks idx per transfer, pulses done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         eff_len   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= ST_STREAM;
                     eff_len   <= len_clamped;
                     idx       <= '0;
                     out_valid <= 1'b1;
                     out_last  <= (len_clamped == LW'(1));
                  end
               end
            end
            ST_STREAM: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= ST_DONE;
                     idx       <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     idx      <= idx_inc;
                     out_last <= (idx_inc == eff_len - LW'(1));
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               idx       <= '0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/vector_result_streamer.md
VECTOR_RESULT_STREAMER -- requirements
Module: vector_result_streamer

Interface
REQ-001 Parameters SHALL be: BITS, default 8, element width; N, default 64, elements per vector; LW, default $clog2(N+1), length/index field width.
REQ-002 Ports SHALL be, in order: clk  in  1  single clock, all state on rising edge; rst  in  1  reset, synchronous, active-high.
REQ-003 Ports SHALL continue: S  in  [BITS-1:0] x N unpacked  result vector from the vector element ALU; start  in  1  single-cycle request to capture and stream S.
REQ-004 Ports SHALL continue: len  in  LW  number of elements to send, starting at element 0; out_ready  in  1  sink can accept an element.
REQ-005 Ports SHALL continue: out_data  out  BITS  current element; out_valid  out  1  out_data is valid; out_index  out  LW  index of out_data; out_last  out  1  current element is the final one.
REQ-006 Ports SHALL end: busy  out  1  capture/stream in progress; done  out  1  one-cycle completion pulse.

Function
REQ-007 FSM states SHALL be IDLE, STREAM, DONE; reset state IDLE.
REQ-008 In IDLE, start=1 with len>=1 SHALL snapshot all N elements of S and the effective length into internal registers at that edge, then enter STREAM.
REQ-009 Effective length SHALL be min(len, N); len>N is clamped, never an error.
REQ-010 In IDLE, start=1 with len=0 SHALL go directly to DONE; no element is presented.
REQ-011 start SHALL be ignored in STREAM and DONE; len is sampled only with an accepted start.
REQ-012 Changes on S after the snapshot SHALL NOT affect streamed data.
REQ-013 In STREAM, out_valid SHALL be 1, out_data = snapshot[idx], out_index = idx, and out_last = (idx == effective length-1).
REQ-014 Latency: the first element SHALL be valid on the cycle after the accepting start edge.
REQ-015 Transfer SHALL occur on an edge with out_valid=1 and out_ready=1; idx increments by 1 per transfer, giving a peak rate of one element/cycle.
REQ-016 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-017 A transfer with out_last=1 SHALL move the FSM to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; a start in the same cycle as DONE is dropped.
REQ-019 busy SHALL be 1 in STREAM and DONE, and 0 in IDLE.
REQ-020 out_valid SHALL be 0 outside STREAM; out_data, out_index and out_last SHALL be 0 outside STREAM.
REQ-021 out_ready SHALL be ignored outside STREAM; out_valid SHALL NOT depend combinationally on out_ready.
REQ-022 idx SHALL never exceed N-1; no wrap-around occurs.

Reset
REQ-023 At rst=1, the next edge SHALL force IDLE with idx=0, effective length=0, and all outputs 0 (out_valid, out_last, busy, done, out_data, out_index).
REQ-024 Reset mid-STREAM or in DONE SHALL abort without a done pulse; the snapshot contents need not be cleared.
REQ-025 rst SHALL take priority over start and out_ready on the same edge.

Structure
REQ-026 The FSM state enum and the LW width helper SHALL live in the shared vector package, vector_pkg.
REQ-027 The snapshot storage SHALL be one sub-module, vector_snapshot_buffer (N x BITS, load-enable, indexed read); FSM and counter stay in the top.

Verification
REQ-028 BITS=8, N=4, S={0x11,0x22,0x33,0x44}, start, len=4, out_ready held 1 -> four consecutive beats 0x11..0x44 with index 0..3, out_last on index 3, done one cycle after, busy low the cycle after that.
REQ-029 Same start, out_ready toggled 1,0,0,1,1,0,1 -> no beat lost or duplicated, data stable while stalled, order 0x11..0x44.
REQ-030 S changed to all 0xFF the cycle after start -> streamed data still 0x11..0x44.
REQ-031 len=0 -> out_valid never asserted, done pulses the cycle after start; len=7 -> exactly 4 beats, out_last on index 3.
REQ-032 A second start pulsed during STREAM and again on the DONE cycle -> ignored, exactly one done.
REQ-033 rst asserted after 2 transfers -> next cycle out_valid=0, busy=0, no done; a following start with len=2 streams 0x11, 0x22.
